// File: rtl/fdc_pkg.sv
// Shared types and defaults for the FDC/DFC blocks.
package fdc_pkg;

  localparam int FDC_CODE_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

endpackage

// File: rtl/dfc_phase_acc.sv
// Phase accumulator: acc += inc while stepping, carry marks the wrap edge.
module dfc_phase_acc #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  input  logic [ACC_W-1:0] inc,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, inc};
  assign carry = step & sum[ACC_W];
  assign acc   = acc_q;

  // clr wins over step so a stop on the wrap edge lands exactly on zero phase
  always_comb begin
    acc_d = acc_q;
    if (clr)       acc_d = '0;
    else if (step) acc_d = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/dfc_nco.sv
// Digitally controlled square-wave source: fout = code * f_clk / 2^ACC_W,
// with code changes deferred to a period boundary.
module dfc_nco
  import fdc_pkg::*;
#(
  parameter int CODE_W = FDC_CODE_W,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              fout,
  output logic              fpulse,
  output logic [CNT_W-1:0]  period_cnt,
  output logic              running
);

  if (CODE_W >= ACC_W) begin : g_bad_widths
    $error("dfc_nco: CODE_W must be smaller than ACC_W");
  end

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   active_q, active_d;
  logic [CODE_W-1:0]   pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                fpulse_q, fpulse_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc;
  logic                carry, clr, step, accept;

  dfc_phase_acc #(.ACC_W(ACC_W)) u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .step  (step),
    .inc   ({{(ACC_W-CODE_W){1'b0}}, active_q}),
    .acc   (acc),
    .carry (carry)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (en && active_q != '0) state_d = RUN;
      RUN: begin
        if (carry && pend_v_q && pend_q == '0) state_d = IDLE;
        else if (!en)                          state_d = STOPPING;
      end
      STOPPING: begin
        if (carry)   state_d = IDLE;
        else if (en) state_d = RUN;
      end
      default:  state_d = IDLE;
    endcase
  end

  // FSM: outputs; the accumulator is held at zero whenever we are or land in IDLE
  always_comb begin
    step    = (state_q != IDLE);
    running = (state_q != IDLE);
    clr     = (state_d == IDLE);
  end

  assign code_ready = !pend_v_q;
  assign accept     = code_valid && code_ready;

  // A code accepted on a carry edge only lands in pend; it is applied at the next carry
  always_comb begin
    active_d = active_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (state_q == IDLE) begin
      if (accept) active_d = code;
    end else begin
      if (carry && pend_v_q) begin
        active_d = pend_q;
        pend_v_d = 1'b0;
      end
      if (accept) begin
        pend_d   = code;
        pend_v_d = 1'b1;
      end
    end
    fpulse_d = carry;
    cnt_d    = cnt_q + CNT_W'(carry);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      fpulse_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      fpulse_q <= fpulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fout       = acc[ACC_W-1];
  assign fpulse     = fpulse_q;
  assign period_cnt = cnt_q;

endmodule

// File: tb/tb_dfc_nco.sv
// Directed bench for dfc_nco with an arithmetic reference model checked every cycle.
module tb_dfc_nco;

  localparam int CODE_W = 5;
  localparam int ACC_W  = 8;
  localparam int CNT_W  = 8;
  localparam int MODULO = 1 << ACC_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [CODE_W-1:0] code = '0;
  logic              code_valid = 1'b0;
  logic              code_ready, fout, fpulse, running;
  logic [CNT_W-1:0]  period_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  dfc_nco #(.CODE_W(CODE_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fout       (fout),
    .fpulse     (fpulse),
    .period_cnt (period_cnt),
    .running    (running)
  );

  always #5 clk = ~clk;

  // Reference model: phase as a plain integer, mode as 0=idle 1=run 2=stopping
  typedef struct {
    int mode;
    int phase;
    int active;
    int pend;
    bit pend_v;
    bit pulse;
    int periods;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_next(mdl_t c, bit rst, bit run_req, int new_code, bit offer);
    mdl_t n;
    bit   take, wrapped;
    int   total;
    n = c;
    if (rst) begin
      n.mode = 0; n.phase = 0; n.active = 0; n.pend = 0;
      n.pend_v = 0; n.pulse = 0; n.periods = 0;
      return n;
    end
    take    = offer && !c.pend_v;
    n.pulse = 0;
    if (c.mode == 0) begin
      if (run_req && c.active != 0) n.mode = 1;
      if (take) n.active = new_code;
    end else begin
      total   = c.phase + c.active;
      wrapped = (total >= MODULO);
      n.phase = total % MODULO;
      if (wrapped) begin
        n.pulse   = 1;
        n.periods = (c.periods + 1) % (1 << CNT_W);
        if (c.pend_v) begin
          n.active = c.pend;
          n.pend_v = 0;
        end
      end
      if (wrapped && (c.mode == 2 || n.active == 0)) begin
        n.mode  = 0;
        n.phase = 0;
      end else if (c.mode == 1 && !run_req) n.mode = 2;
      else if (c.mode == 2 && run_req)      n.mode = 1;
      if (take) begin
        n.pend   = new_code;
        n.pend_v = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, reset, en, int'(code), code_valid);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_fout",       32'(fout),       32'(m.phase >= MODULO / 2));
      chk("model_fpulse",     32'(fpulse),     32'(m.pulse));
      chk("model_period_cnt", 32'(period_cnt), 32'(m.periods));
      chk("model_running",    32'(running),    32'(m.mode != 0));
      chk("model_code_ready", 32'(code_ready), 32'(!m.pend_v));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until the next fpulse (bounded), plus how many of them had fout high
  task automatic wait_pulse(output int n, output int hi);
    n = 0; hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (fout) hi++;
    end while (!fpulse && n < 300);
    if (!fpulse) chk("pulse_timeout", 32'(fpulse), 32'd1);
  endtask

  task automatic count_pulses(int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (fpulse) cnt++;
    end
  endtask

  task automatic offer(int c);
    code = CODE_W'(c);
    code_valid = 1'b1;
    step(1);
    code_valid = 1'b0;
  endtask

  initial begin
    int n, hi, saved;
    step(2);
    chk_en = 1'b1;
    reset = 1'b0;
    chk("rst_fout", 32'(fout), 0);
    chk("rst_cnt", 32'(period_cnt), 0);
    chk("rst_ready", 32'(code_ready), 1);
    chk("rst_running", 32'(running), 0);

    // 1: basic run at code 16
    offer(16);
    chk("idle_ready_after_accept", 32'(code_ready), 1);
    en = 1'b1;
    step(1);
    chk("t1_running", 32'(running), 1);
    wait_pulse(n, hi); chk("t1_first_period", n, 16);
    wait_pulse(n, hi); chk("t1_period", n, 16); chk("t1_high", hi, 8);
    wait_pulse(n, hi); chk("t1_period3", n, 16);
    wait_pulse(n, hi); chk("t1_period4", n, 16);
    chk("t1_cnt4", 32'(period_cnt), 4);

    // 2: code 8 offered mid-period
    step(5);
    offer(8);
    chk("t2_ready_low", 32'(code_ready), 0);
    wait_pulse(n, hi); chk("t2_rest_of_period", n, 10);
    chk("t2_ready_back", 32'(code_ready), 1);
    wait_pulse(n, hi); chk("t2_period32", n, 32); chk("t2_high32", hi, 16);

    // 3: back to 16, then accept code 8 exactly on a wrap edge
    step(2);
    offer(16);
    wait_pulse(n, hi); chk("t3_rest32", n, 29);
    wait_pulse(n, hi); chk("t3_period16", n, 16);
    step(15);
    offer(8);
    chk("t3_accept_on_wrap", 32'(fpulse), 1);
    chk("t3_ready_low", 32'(code_ready), 0);
    wait_pulse(n, hi); chk("t3_one_more_16", n, 16);
    wait_pulse(n, hi); chk("t3_then_32", n, 32);

    // 4: stop request completes the period
    step(2);
    offer(16);
    wait_pulse(n, hi); chk("t4_rest32", n, 29);
    wait_pulse(n, hi); chk("t4_period16", n, 16);
    step(3);
    en = 1'b0;
    wait_pulse(n, hi); chk("t4_stop_completes", n, 13);
    chk("t4_idle", 32'(running), 0);
    chk("t4_fout0", 32'(fout), 0);
    saved = int'(period_cnt);
    count_pulses(40, n); chk("t4_no_pulses", n, 0);
    chk("t4_cnt_hold", 32'(period_cnt), 32'(saved));
    en = 1'b1;
    step(1);
    chk("t4_restart", 32'(running), 1);
    wait_pulse(n, hi); chk("t4_restart_period", n, 16);
    step(3);
    en = 1'b0;
    step(2);
    chk("t4_stopping_running", 32'(running), 1);
    en = 1'b1;
    wait_pulse(n, hi); chk("t4_resume_no_phase_change", n, 11);
    wait_pulse(n, hi); chk("t4_resume_period", n, 16);

    // 5: zero code stops at the next wrap; en with active 0 stays idle
    step(4);
    offer(0);
    wait_pulse(n, hi); chk("t5_rest", n, 11);
    chk("t5_idle", 32'(running), 0);
    chk("t5_fout0", 32'(fout), 0);
    count_pulses(20, n); chk("t5_no_pulses", n, 0);
    chk("t5_still_idle", 32'(running), 0);

    // 6: reset mid-high, then counter wrap at max code
    offer(16);
    step(1);
    chk("t6_running", 32'(running), 1);
    step(10);
    chk("t6_high_phase", 32'(fout), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t6_rst_fout", 32'(fout), 0);
    chk("t6_rst_fpulse", 32'(fpulse), 0);
    chk("t6_rst_cnt", 32'(period_cnt), 0);
    chk("t6_rst_ready", 32'(code_ready), 1);
    chk("t6_rst_running", 32'(running), 0);
    offer(31);
    step(1);
    count_pulses(4096, n); chk("t6_pulses_4096", n, 496);
    chk("t6_cnt_wrapped", 32'(period_cnt), 240);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
